// File: rtl/prbs_sync_checker.sv
// Purpose: PRBS7/15/23/31 receive checker. It seeds from the stream, hunts for LOCK_BEATS
//          clean beats, then counts checked bits and bit errors while locked.
// Latency: counters and error_beat are registered one cycle after the beat. locked
//          follows the state register.
// Backpressure: none. A beat is consumed on every cycle in which data_in_valid is high.
// Ports: clk/rstn         - clock, async active-low reset
//        poly_sel         - 0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31; a change forces reseed
//        clear_counters   - synchronous clear of total_bits / total_bit_errors
//        data_in[_valid]  - WIDTH received bits, MSB earliest in time
//        locked, total_bits, total_bit_errors, error_beat - status outputs
module prbs_sync_checker #(
    parameter int WIDTH       = 1,
    parameter int COUNT_WIDTH = 32,
    parameter int LOCK_BEATS  = 16,
    parameter int LOSS_BEATS  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [1:0]             poly_sel,
    input  logic                   clear_counters,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   data_in_valid,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] total_bits,
    output logic [COUNT_WIDTH-1:0] total_bit_errors,
    output logic                   error_beat
);

    typedef enum logic [1:0] {ST_SEED, ST_HUNT, ST_LOCKED} state_t;

    localparam int CLEAN_W = $clog2(LOCK_BEATS + 1);
    localparam int BAD_W   = $clog2(LOSS_BEATS + 1);
    localparam int MIS_W   = $clog2(WIDTH + 1);
    localparam int SUM_W   = COUNT_WIDTH + 4;
    localparam logic [5:0]         WIDTH_6   = 6'(WIDTH);
    localparam logic [CLEAN_W-1:0] LOCK_LAST = CLEAN_W'(LOCK_BEATS - 1);
    localparam logic [BAD_W-1:0]   LOSS_LAST = BAD_W'(LOSS_BEATS - 1);

    state_t                 state_q, state_d;
    logic [30:0]            lfsr_q, lfsr_d;
    logic [5:0]             seed_q, seed_d;
    logic [CLEAN_W-1:0]     clean_q, clean_d;
    logic [BAD_W-1:0]       bad_q, bad_d;
    logic [1:0]             poly_q;
    logic [COUNT_WIDTH-1:0] bits_d, errs_d;
    logic                   eb_d;

    logic [4:0]             tap_n, tap_t;
    logic [5:0]             poly_len;
    logic [30:0]            walk;
    logic [MIS_W-1:0]       mis_cnt;
    logic                   pred;

    // Saturating add. The extra headroom bits catch an increment that is larger than
    // the counter range, for example WIDTH=8 into a 3-bit counter.
    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [3:0] inc);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(inc);
        if (s[SUM_W-1:COUNT_WIDTH] != '0) return '1;
        return s[COUNT_WIDTH-1:0];
    endfunction

    // Tap indices: the LFSR holds s[0] as the newest bit, so s[k-1] is the bit k steps back.
    always_comb begin
        tap_n    = 5'd30;
        tap_t    = 5'd27;
        poly_len = 6'd31;
        unique case (poly_sel)
            2'd0: begin tap_n = 5'd6;  tap_t = 5'd5;  poly_len = 6'd7;  end
            2'd1: begin tap_n = 5'd14; tap_t = 5'd13; poly_len = 6'd15; end
            2'd2: begin tap_n = 5'd22; tap_t = 5'd17; poly_len = 6'd23; end
            2'd3: begin tap_n = 5'd30; tap_t = 5'd27; poly_len = 6'd31; end
        endcase
    end

    // Walk the beat bit by bit, earliest bit first. SEED loads the received bits into
    // the LFSR. Otherwise the LFSR advances on its own prediction, so a corrupted bit
    // never pollutes the reference.
    always_comb begin
        walk    = lfsr_q;
        mis_cnt = '0;
        pred    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            pred = walk[tap_n] ^ walk[tap_t];
            if (state_q == ST_SEED) begin
                walk = {walk[29:0], data_in[i]};
            end else begin
                if (data_in[i] != pred) mis_cnt = mis_cnt + 1'b1;
                walk = {walk[29:0], pred};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        clean_d = clean_q;
        bad_d   = bad_q;
        bits_d  = total_bits;
        errs_d  = total_bit_errors;
        eb_d    = 1'b0;
        if (poly_sel != poly_q) begin
            // A polynomial change makes the reference meaningless. Reseed and drop this beat.
            state_d = ST_SEED;
            seed_d  = '0;
            clean_d = '0;
            bad_d   = '0;
        end else if (data_in_valid) begin
            lfsr_d = walk;
            unique case (state_q)
                ST_SEED: begin
                    seed_d = seed_q + WIDTH_6;
                    if (seed_d >= poly_len) begin
                        state_d = ST_HUNT;
                        clean_d = '0;
                    end
                end
                ST_HUNT: begin
                    if (mis_cnt != '0) begin
                        state_d = ST_SEED;
                        seed_d  = '0;
                    end else if (clean_q == LOCK_LAST) begin
                        state_d = ST_LOCKED;
                        clean_d = '0;
                        bad_d   = '0;
                    end else begin
                        clean_d = clean_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    bits_d = sat_add(total_bits, 4'(WIDTH));
                    errs_d = sat_add(total_bit_errors, 4'(mis_cnt));
                    if (mis_cnt != '0) begin
                        eb_d = 1'b1;
                        if (bad_q == LOSS_LAST) begin
                            state_d = ST_SEED;
                            seed_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end
        // Clear overrides anything this beat would have added.
        if (clear_counters) begin
            bits_d = '0;
            errs_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_SEED;
            lfsr_q           <= '0;
            seed_q           <= '0;
            clean_q          <= '0;
            bad_q            <= '0;
            poly_q           <= 2'd0;
            total_bits       <= '0;
            total_bit_errors <= '0;
            error_beat       <= 1'b0;
        end else begin
            state_q          <= state_d;
            lfsr_q           <= lfsr_d;
            seed_q           <= seed_d;
            clean_q          <= clean_d;
            bad_q            <= bad_d;
            poly_q           <= poly_sel;
            total_bits       <= bits_d;
            total_bit_errors <= errs_d;
            error_beat       <= eb_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_prbs_sync_checker.sv
// Three checker instances: WIDTH=1, WIDTH=4, and WIDTH=8 with 4-bit counters.
// Random PRBS streams are compared every cycle against a bit-history reference model.
module tb_prbs_sync_checker;

    localparam int LOCKB = 16;
    localparam int LOSSB = 4;
    localparam int M_SEED = 0, M_HUNT = 1, M_LOCKED = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn [3];
    logic [1:0] psel [3];
    logic       clr  [3];
    logic [7:0] din  [3];
    logic       vld  [3];

    logic        lk0, lk1, lk2, eb0, eb1, eb2;
    logic [31:0] tbits0, terrs0, tbits1, terrs1;
    logic [3:0]  tbits2, terrs2;

    prbs_sync_checker #(.WIDTH(1)) u_w1 (
        .clk(clk), .rstn(rstn[0]), .poly_sel(psel[0]), .clear_counters(clr[0]),
        .data_in(din[0][0:0]), .data_in_valid(vld[0]), .locked(lk0),
        .total_bits(tbits0), .total_bit_errors(terrs0), .error_beat(eb0));

    prbs_sync_checker #(.WIDTH(4)) u_w4 (
        .clk(clk), .rstn(rstn[1]), .poly_sel(psel[1]), .clear_counters(clr[1]),
        .data_in(din[1][3:0]), .data_in_valid(vld[1]), .locked(lk1),
        .total_bits(tbits1), .total_bit_errors(terrs1), .error_beat(eb1));

    prbs_sync_checker #(.WIDTH(8), .COUNT_WIDTH(4)) u_w8 (
        .clk(clk), .rstn(rstn[2]), .poly_sel(psel[2]), .clear_counters(clr[2]),
        .data_in(din[2]), .data_in_valid(vld[2]), .locked(lk2),
        .total_bits(tbits2), .total_bit_errors(terrs2), .error_beat(eb2));

    int total = 0;
    int bad   = 0;
    bit gap_en = 1'b1;

    // Reference model state, one slot per instance.
    int          m_mode [3];
    int          m_seed [3];
    int          m_clean[3];
    int          m_bad  [3];
    longint      m_bits [3];
    longint      m_errs [3];
    bit          m_eb   [3];
    logic [30:0] m_h    [3];   // m_h[k][j] = reference bit j+1 steps in the past
    logic [1:0]  m_pq   [3];
    logic [30:0] g_s    [3];   // stream generator history

    function automatic int wd(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction
    function automatic longint cmax(input int k);
        return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction
    function automatic int plen(input logic [1:0] ps);
        return (ps == 0) ? 7 : (ps == 1) ? 15 : (ps == 2) ? 23 : 31;
    endfunction
    function automatic int ptap(input logic [1:0] ps);
        return (ps == 0) ? 6 : (ps == 1) ? 14 : (ps == 2) ? 18 : 28;
    endfunction
    function automatic longint g_bits(input int k);
        return (k == 0) ? longint'(tbits0) : (k == 1) ? longint'(tbits1) : longint'(tbits2);
    endfunction
    function automatic longint g_errs(input int k);
        return (k == 0) ? longint'(terrs0) : (k == 1) ? longint'(terrs1) : longint'(terrs2);
    endfunction
    function automatic logic g_lk(input int k);
        return (k == 0) ? lk0 : (k == 1) ? lk1 : lk2;
    endfunction
    function automatic logic g_eb(input int k);
        return (k == 0) ? eb0 : (k == 1) ? eb1 : eb2;
    endfunction

    task automatic chk(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_mode[k] = M_SEED; m_seed[k] = 0; m_clean[k] = 0; m_bad[k] = 0;
        m_bits[k] = 0; m_errs[k] = 0; m_eb[k] = 1'b0; m_h[k] = '0; m_pq[k] = 2'd0;
    endtask

    task automatic model_step(input int k, input logic [7:0] d, input bit v, input bit c,
                              input logic [1:0] ps);
        int n, t, nerr;
        bit b, p, chg;
        chg = (ps != m_pq[k]);
        m_pq[k] = ps;
        m_eb[k] = 1'b0;
        if (c) begin m_bits[k] = 0; m_errs[k] = 0; end
        if (chg) begin
            m_mode[k] = M_SEED; m_seed[k] = 0; m_clean[k] = 0; m_bad[k] = 0;
        end else if (v) begin
            n = plen(ps); t = ptap(ps); nerr = 0;
            for (int i = wd(k) - 1; i >= 0; i--) begin
                b = d[i];
                p = m_h[k][n-1] ^ m_h[k][t-1];
                if (m_mode[k] == M_SEED) m_h[k] = {m_h[k][29:0], b};
                else begin
                    if (b != p) nerr++;
                    m_h[k] = {m_h[k][29:0], p};
                end
            end
            if (m_mode[k] == M_SEED) begin
                m_seed[k] += wd(k);
                if (m_seed[k] >= n) begin m_mode[k] = M_HUNT; m_clean[k] = 0; end
            end else if (m_mode[k] == M_HUNT) begin
                if (nerr > 0) begin m_mode[k] = M_SEED; m_seed[k] = 0; end
                else begin
                    m_clean[k]++;
                    if (m_clean[k] >= LOCKB) begin m_mode[k] = M_LOCKED; m_bad[k] = 0; end
                end
            end else begin
                if (!c) begin
                    m_bits[k] = (m_bits[k] + wd(k) > cmax(k)) ? cmax(k) : m_bits[k] + wd(k);
                    m_errs[k] = (m_errs[k] + nerr > cmax(k)) ? cmax(k) : m_errs[k] + nerr;
                end
                if (nerr > 0) begin
                    m_eb[k] = 1'b1;
                    m_bad[k]++;
                    if (m_bad[k] >= LOSSB) begin m_mode[k] = M_SEED; m_seed[k] = 0; end
                end else m_bad[k] = 0;
            end
        end
    endtask

    task automatic cyc(input int k, input logic [7:0] d, input bit v, input bit c,
                       input logic [1:0] ps);
        @(negedge clk);
        din[k] = d; vld[k] = v; clr[k] = c; psel[k] = ps;
        @(posedge clk);
        model_step(k, d, v, c, ps);
        #1;
        chk($sformatf("d%0d.locked", k), g_lk(k), (m_mode[k] == M_LOCKED));
        chk($sformatf("d%0d.bits", k), g_bits(k), m_bits[k]);
        chk($sformatf("d%0d.errs", k), g_errs(k), m_errs[k]);
        chk($sformatf("d%0d.error_beat", k), g_eb(k), m_eb[k]);
        vld[k] = 1'b0; clr[k] = 1'b0;
    endtask

    task automatic gen_seed(input int k);
        g_s[k] = 31'($urandom);
        g_s[k][0] = 1'b1;
    endtask

    task automatic beat(input int k, input logic [1:0] ps, input logic [7:0] mask, input bit c);
        logic [7:0] d;
        bit nb;
        if (gap_en && $urandom_range(0, 3) == 0) cyc(k, 8'h00, 1'b0, 1'b0, ps);
        d = 8'h00;
        for (int i = wd(k) - 1; i >= 0; i--) begin
            nb = g_s[k][plen(ps)-1] ^ g_s[k][ptap(ps)-1];
            g_s[k] = {g_s[k][29:0], nb};
            d[i] = nb ^ mask[i];
        end
        cyc(k, d, 1'b1, c, ps);
    endtask

    task automatic wait_lock(input int k, input logic [1:0] ps, input int maxb, output int n);
        n = -1;
        for (int b = 1; b <= maxb; b++) begin
            beat(k, ps, 8'h00, 1'b0);
            if (g_lk(k)) begin n = b; break; end
        end
    endtask

    task automatic rst(input int k);
        @(negedge clk);
        rstn[k] = 1'b0;
        #1;
        chk($sformatf("d%0d.rst_locked", k), g_lk(k), 0);
        chk($sformatf("d%0d.rst_bits", k), g_bits(k), 0);
        chk($sformatf("d%0d.rst_errs", k), g_errs(k), 0);
        chk($sformatf("d%0d.rst_eb", k), g_eb(k), 0);
        model_reset(k);
        @(negedge clk);
        rstn[k] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lock_at;
        longint b0, e0;
        logic [7:0] msk;
        logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0; psel[k] = 2'd0; clr[k] = 1'b0; din[k] = 8'h00; vld[k] = 1'b0;
            model_reset(k);
        end
        repeat (2) @(posedge clk);

        // WIDTH=1 PRBS31: lock after 31 seed + 16 hunt beats, 153 bits over 200 beats.
        rst(0);
        cyc(0, 8'h00, 1'b0, 1'b0, 2'd3);
        gen_seed(0);
        lock_at = -1;
        for (int b = 1; b <= 200; b++) begin
            beat(0, 2'd3, 8'h00, 1'b0);
            if (lock_at < 0 && lk0) lock_at = b;
        end
        chk("s1.lock_beat", lock_at, 47);
        chk("s1.total_bits", tbits0, 153);
        chk("s1.total_errs", terrs0, 0);

        // WIDTH=4 PRBS7.
        rst(1);
        gen_seed(1);
        wait_lock(1, 2'd0, 60, n);
        chk("s2.lock_beats", n, 18);
        repeat (5) beat(1, 2'd0, 8'h00, 1'b0);
        e0 = terrs1;
        beat(1, 2'd0, 8'b0110, 1'b0);
        chk("s2.eb_pulse", eb1, 1);
        chk("s2.err_inc", longint'(terrs1) - e0, 2);
        chk("s2.lock_hold", lk1, 1);
        beat(1, 2'd0, 8'h00, 1'b0);
        chk("s2.eb_drop", eb1, 0);

        // Four errored beats lose lock. Counters then hold until the relock.
        b0 = tbits1;
        for (int i = 0; i < 4; i++) beat(1, 2'd0, 8'($urandom_range(1, 15)), 1'b0);
        chk("s2.loss", lk1, 0);
        chk("s2.bits_at_loss", tbits1, b0 + 16);
        wait_lock(1, 2'd0, 60, n);
        chk("s2.relock_beats", n, 18);
        chk("s2.bits_held", tbits1, b0 + 16);

        // Clear with a simultaneous beat discards that beat.
        repeat (3) beat(1, 2'd0, 8'h00, 1'b0);
        beat(1, 2'd0, 8'h00, 1'b1);
        chk("s2.clr_bits", tbits1, 0);
        chk("s2.clr_errs", terrs1, 0);
        beat(1, 2'd0, 8'h00, 1'b0);
        chk("s2.resume_bits", tbits1, 4);

        // Random errors, gaps and clears.
        for (int i = 0; i < 150; i++) begin
            msk = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 15)) : 8'h00;
            beat(1, 2'd0, msk, ($urandom_range(0, 19) == 0));
        end

        // Polynomial switches: to PRBS31, then 3->1 while locked.
        cyc(1, 8'h00, 1'b0, 1'b0, 2'd3);
        wait_lock(1, 2'd3, 100, n);
        chk("s2.lock31_beats", n, 24);
        repeat (3) beat(1, 2'd3, 8'h00, 1'b0);
        b0 = tbits1;
        e0 = terrs1;
        d = 8'($urandom_range(0, 15));
        cyc(1, d, 1'b1, 1'b0, 2'd1);
        chk("s2.psel_unlock", lk1, 0);
        chk("s2.psel_bits_kept", tbits1, b0);
        chk("s2.psel_errs_kept", terrs1, e0);
        wait_lock(1, 2'd1, 100, n);
        chk("s2.lock15_beats", n, 20);
        for (int i = 0; i < 4; i++) beat(1, 2'd1, 8'hF, 1'b0);
        repeat (9) beat(1, 2'd1, 8'h00, 1'b0);
        chk("s2.mid_hunt", lk1, 0);
        rst(1);

        // WIDTH=8 with 4-bit counters: each counter saturates at 15 on its own.
        rst(2);
        cyc(2, 8'h00, 1'b0, 1'b0, 2'd2);
        gen_seed(2);
        wait_lock(2, 2'd2, 60, n);
        chk("s3.lock_beats", n, 19);
        beat(2, 2'd2, 8'h00, 1'b0);
        chk("s3.bits_8", tbits2, 8);
        beat(2, 2'd2, 8'h00, 1'b0);
        chk("s3.bits_sat", tbits2, 15);
        beat(2, 2'd2, 8'h03, 1'b0);
        chk("s3.bits_stay", tbits2, 15);
        chk("s3.errs_2", terrs2, 2);
        beat(2, 2'd2, 8'hFF, 1'b0);
        beat(2, 2'd2, 8'hFF, 1'b0);
        chk("s3.errs_sat", terrs2, 15);
        chk("s3.still_locked", lk2, 1);
        beat(2, 2'd2, 8'hFF, 1'b0);
        chk("s3.loss", lk2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
